// File: rtl/recovery_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : recovery_scheduler
// Brief   : Halts all cores, copies a healthy neighbour's register file into a
//           faulted core, then resumes; round-robin over pending core errors.
// Rev     : 1.0
// ============================================================================
module recovery_scheduler #(
    parameter int NUM_CORES    = 4,
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int HALT_TIMEOUT = 15
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_CORES-1:0]         error_i,
    input  logic [NUM_CORES-1:0]         halted_i,
    input  logic [DATA_WIDTH-1:0]        rd_data_i,
    output logic [NUM_CORES-1:0]         halt_o,
    output logic                         resume_o,
    output logic [$clog2(NUM_CORES)-1:0] src_sel_o,
    output logic [$clog2(NUM_CORES)-1:0] dst_sel_o,
    output logic [ADDR_WIDTH-1:0]        rd_addr_o,
    output logic                         wr_en_o,
    output logic [ADDR_WIDTH-1:0]        wr_addr_o,
    output logic [DATA_WIDTH-1:0]        wr_data_o,
    output logic                         busy_o,
    output logic                         fail_o,
    output logic [7:0]                   recovery_count_o
);

    localparam int SEL_W   = $clog2(NUM_CORES);
    localparam int NUM_REG = 2 ** ADDR_WIDTH;
    localparam int CNT_W   = ADDR_WIDTH + 1;
    localparam int TMO_W   = $clog2(HALT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HALT   = 3'd1,
        S_COPY   = 3'd2,
        S_RESUME = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    state_t               state_q,   state_d;
    logic [NUM_CORES-1:0] pending_q, pending_d;
    logic [SEL_W-1:0]     last_q,    last_d;
    logic [SEL_W-1:0]     dst_q,     dst_d;
    logic [SEL_W-1:0]     src_q,     src_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [TMO_W-1:0]     tmo_q,     tmo_d;
    logic [7:0]           count_q,   count_d;

    logic                 grant_found;
    logic [SEL_W-1:0]     grant_idx;

    // Round-robin search begins at the core after the last one granted.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            if (!grant_found && pending_q[(int'(last_q) + i) % NUM_CORES]) begin
                grant_found = 1'b1;
                grant_idx   = SEL_W'((int'(last_q) + i) % NUM_CORES);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        dst_d     = dst_q;
        src_d     = src_q;
        cnt_d     = '0;
        tmo_d     = tmo_q;
        count_d   = count_q;
        pending_d = pending_q | error_i;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    dst_d   = grant_idx;
                    src_d   = (grant_idx == SEL_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
                    last_d  = grant_idx;
                    tmo_d   = '0;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                tmo_d = tmo_q + 1'b1;
                if (&halted_i) begin
                    state_d = S_COPY;
                end else if (tmo_q == TMO_W'(HALT_TIMEOUT - 1)) begin
                    state_d = S_FAIL;
                end
            end
            S_COPY: begin
                // One extra cycle after the last read lets its write land.
                if (cnt_q == CNT_W'(NUM_REG)) begin
                    state_d = S_RESUME;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESUME: begin
                pending_d[dst_q] = error_i[dst_q];
                if (count_q != 8'hFF) begin
                    count_d = count_q + 8'd1;
                end
                state_d = S_IDLE;
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            last_q    <= SEL_W'(NUM_CORES - 1);
            dst_q     <= '0;
            src_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            count_q   <= count_d;
        end
    end

    assign busy_o           = (state_q != S_IDLE);
    assign fail_o           = (state_q == S_FAIL);
    assign resume_o         = (state_q == S_RESUME);
    assign halt_o           = ((state_q == S_HALT) || (state_q == S_COPY) || (state_q == S_FAIL))
                              ? '1 : '0;
    assign src_sel_o        = src_q;
    assign dst_sel_o        = dst_q;
    assign recovery_count_o = count_q;

    // Read data arrives one cycle after its address, so write k trails read k.
    assign rd_addr_o        = cnt_q[ADDR_WIDTH-1:0];
    assign wr_en_o          = (state_q == S_COPY) && (cnt_q != '0);
    assign wr_addr_o        = wr_en_o ? ADDR_WIDTH'(cnt_q - 1'b1) : '0;
    assign wr_data_o        = wr_en_o ? rd_data_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_recovery_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_recovery_scheduler
// Brief   : Randomized and directed bench for recovery_scheduler against a
//           timeline-based reference model.
// Rev     : 1.0
// ============================================================================
module tb_recovery_scheduler;

    localparam int NC      = 4;
    localparam int AW      = 5;
    localparam int DW      = 32;
    localparam int HT      = 15;
    localparam int NUM_REG = 2 ** AW;
    localparam int RES_K   = NUM_REG + 3;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [NC-1:0] error_i;
    logic [NC-1:0] halted_i;
    logic [DW-1:0] rd_data_i;
    logic [NC-1:0] halt_o;
    logic          resume_o;
    logic [1:0]    src_sel_o;
    logic [1:0]    dst_sel_o;
    logic [AW-1:0] rd_addr_o;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic          busy_o;
    logic          fail_o;
    logic [7:0]    recovery_count_o;

    logic          ack_mode;
    logic [NC-1:0] halted_drv;
    assign halted_i = ack_mode ? halt_o : halted_drv;

    recovery_scheduler #(
        .NUM_CORES   (NC),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .HALT_TIMEOUT(HT)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .error_i         (error_i),
        .halted_i        (halted_i),
        .rd_data_i       (rd_data_i),
        .halt_o          (halt_o),
        .resume_o        (resume_o),
        .src_sel_o       (src_sel_o),
        .dst_sel_o       (dst_sel_o),
        .rd_addr_o       (rd_addr_o),
        .wr_en_o         (wr_en_o),
        .wr_addr_o       (wr_addr_o),
        .wr_data_o       (wr_data_o),
        .busy_o          (busy_o),
        .fail_o          (fail_o),
        .recovery_count_o(recovery_count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Source register files seen by the scheduler's read port.
    logic [DW-1:0] regs [NC][NUM_REG];
    logic [DW-1:0] rd_next;

    // Reference model: a recovery is a fixed timeline of offsets from its grant cycle.
    bit         model_en;
    bit [NC-1:0] m_pend;
    bit         m_busy;
    int         m_k, m_g, m_src, m_last, m_count;
    int         cyc, last_resume_cyc, wr_cnt;

    task automatic model_reset();
        m_pend  = '0;
        m_busy  = 1'b0;
        m_k     = 0;
        m_g     = 0;
        m_src   = 0;
        m_last  = NC - 1;
        m_count = 0;
        rd_next = '0;
    endtask

    task automatic model_check();
        bit found;
        int c, j;
        if (!m_busy && m_pend != '0) begin
            found = 1'b0;
            for (int i = 1; i <= NC; i++) begin
                c = (m_last + i) % NC;
                if (!found && m_pend[c]) begin
                    found = 1'b1;
                    m_g   = c;
                end
            end
            m_src  = (m_g + 1) % NC;
            m_last = m_g;
            m_busy = 1'b1;
            m_k    = 0;
        end
        j = m_k - 2;
        chk("halt",   32'(halt_o),   (m_busy && m_k >= 1 && m_k <= NUM_REG + 2) ? 32'hF : 32'h0);
        chk("resume", 32'(resume_o), 32'(m_busy && m_k == RES_K));
        chk("busy",   32'(busy_o),   32'(m_busy && m_k >= 1));
        chk("wr_en",  32'(wr_en_o),  32'(m_busy && j >= 1 && j <= NUM_REG));
        chk("fail",   32'(fail_o),   32'h0);
        chk("count",  32'(recovery_count_o), 32'(m_count));
        if (m_busy && m_k >= 1) begin
            chk("dst_sel", 32'(dst_sel_o), 32'(m_g));
            chk("src_sel", 32'(src_sel_o), 32'(m_src));
        end
        if (m_busy && j >= 0 && j < NUM_REG)
            chk("rd_addr", 32'(rd_addr_o), 32'(j));
        if (m_busy && j >= 1 && j <= NUM_REG) begin
            chk("wr_addr", 32'(wr_addr_o), 32'(j - 1));
            chk("wr_data", wr_data_o, regs[m_src][j-1]);
        end
    endtask

    task automatic model_update(input logic [NC-1:0] err);
        if (m_busy && m_k == RES_K) begin
            m_pend       = m_pend | err;
            m_pend[m_g]  = err[m_g];
            if (m_count < 255) m_count++;
            m_busy = 1'b0;
        end else begin
            m_pend = m_pend | err;
            if (m_busy) m_k++;
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic cycle(input logic [NC-1:0] err);
        error_i   = err;
        rd_data_i = rd_next;
        @(negedge clk);
        if (model_en) model_check();
        if (resume_o) last_resume_cyc = cyc;
        if (wr_en_o) wr_cnt++;
        rd_next = regs[src_sel_o][rd_addr_o];
        if (model_en) model_update(err);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    int base_cnt, halt_n, guard;

    initial begin
        for (int c = 0; c < NC; c++)
            for (int a = 0; a < NUM_REG; a++)
                regs[c][a] = $urandom;
        rst_i      = 1'b1;
        error_i    = '0;
        rd_data_i  = '0;
        ack_mode   = 1'b1;
        halted_drv = '0;
        model_en   = 1'b1;
        cyc        = 0;
        wr_cnt     = 0;
        last_resume_cyc = -1;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_halt",  32'(halt_o), 0);
        chk("rst_busy",  32'(busy_o), 0);
        chk("rst_fail",  32'(fail_o), 0);
        chk("rst_count", 32'(recovery_count_o), 0);
        chk("rst_wren",  32'(wr_en_o), 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Single error on core 2.
        wr_cnt = 0;
        base_cnt = cyc;
        cycle(4'b0100);
        repeat (45) cycle('0);
        chk("lat_single", 32'(last_resume_cyc - base_cnt), 32'(NUM_REG + 4));
        chk("writes_single", 32'(wr_cnt), 32'(NUM_REG));
        chk("dst_single", 32'(dst_sel_o), 2);
        chk("src_single", 32'(src_sel_o), 3);
        chk("cnt_single", 32'(recovery_count_o), 1);

        // Simultaneous errors on cores 0 and 3 from reset.
        do_reset();
        cycle(4'b1001);
        repeat (90) cycle('0);
        chk("cnt_dual", 32'(recovery_count_o), 2);
        chk("dst_dual", 32'(dst_sel_o), 3);
        chk("src_dual", 32'(src_sel_o), 0);

        // Core 1 errors while core 2 is being repaired.
        cycle(4'b0100);
        repeat (12) cycle('0);
        cycle(4'b0010);
        repeat (80) cycle('0);
        chk("cnt_copyerr", 32'(recovery_count_o), 4);
        chk("dst_copyerr", 32'(dst_sel_o), 1);

        // Random error traffic.
        repeat (1500) begin
            if ($urandom_range(0, 15) == 0) cycle(4'($urandom));
            else                            cycle('0);
        end
        repeat (200) cycle('0);

        // Asynchronous reset in the middle of a copy.
        cycle(4'b0001);
        guard = 0;
        while (!(m_busy && m_k == 12) && guard < 200) begin
            cycle('0);
            guard++;
        end
        chk("midcopy_reached", 32'(guard < 200), 1);
        chk("midcopy_rdaddr", 32'(rd_addr_o), 10);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_halt",   32'(halt_o), 0);
        chk("arst_busy",   32'(busy_o), 0);
        chk("arst_wren",   32'(wr_en_o), 0);
        chk("arst_resume", 32'(resume_o), 0);
        chk("arst_count",  32'(recovery_count_o), 0);
        chk("arst_rdaddr", 32'(rd_addr_o), 0);
        chk("arst_wraddr", 32'(wr_addr_o), 0);
        chk("arst_dst",    32'(dst_sel_o), 0);
        chk("arst_src",    32'(src_sel_o), 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
        last_resume_cyc = -1;
        repeat (60) cycle('0);
        chk("arst_no_resume", 32'(last_resume_cyc), 32'hFFFF_FFFF);
        chk("arst_idle", 32'(busy_o), 0);

        // Saturation: continuous errors on all cores.
        repeat (260 * (NUM_REG + 4) + 40) cycle(4'hF);
        chk("cnt_sat", 32'(recovery_count_o), 255);

        // Halt timeout: core 3 never acknowledges.
        do_reset();
        model_en   = 1'b0;
        ack_mode   = 1'b0;
        halted_drv = 4'b0111;
        wr_cnt     = 0;
        halt_n     = 0;
        cycle(4'b0001);
        repeat (40) begin
            if (busy_o && !fail_o) halt_n++;
            cycle('0);
        end
        chk("tmo_halt_cycles", 32'(halt_n), HT);
        chk("tmo_fail", 32'(fail_o), 1);
        chk("tmo_busy", 32'(busy_o), 1);
        chk("tmo_halt", 32'(halt_o), 32'hF);
        chk("tmo_writes", 32'(wr_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/recovery_scheduler.md
RECOVERY_SCHEDULER -- requirements
Module: recovery_scheduler

Interface
REQ-001 Parameter NUM_CORES, default 4: cores monitored; SHALL be 2..8.
REQ-002 Parameter ADDR_WIDTH, default 5: register-file address width; NUM_REG = 2**ADDR_WIDTH.
REQ-003 Parameter DATA_WIDTH, default 32: register data width.
REQ-004 Parameter HALT_TIMEOUT, default 15: maximum cycles to wait for halt acknowledge.
REQ-005 Ports SHALL be exactly as follows, one clock domain. Reset is asynchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- error_i  in  NUM_CORES  per-core error flag, level or pulse
- halted_i  in  NUM_CORES  per-core halt acknowledge
- rd_data_i  in  DATA_WIDTH  source register data, valid one cycle after rd_addr_o
- halt_o  out  NUM_CORES  halt request per core
- resume_o  out  1  one-cycle resume pulse to all cores
- src_sel_o  out  clog2(NUM_CORES)  core whose register file is read
- dst_sel_o  out  clog2(NUM_CORES)  core being repaired
- rd_addr_o  out  ADDR_WIDTH  source read address
- wr_en_o  out  1  destination write strobe
- wr_addr_o  out  ADDR_WIDTH  destination write address
- wr_data_o  out  DATA_WIDTH  destination write data
- busy_o  out  1  recovery in progress
- fail_o  out  1  sticky halt-timeout flag
- recovery_count_o  out  8  completed recoveries, saturating

Function
REQ-006 Each error_i bit SHALL set a sticky pending bit on the rising edge of clk_i; a pending bit clears only in RESUME for the granted core.
REQ-007 FSM states: IDLE, HALT, COPY, RESUME, FAIL.
REQ-008 IDLE: when any pending bit is set, the block SHALL grant one core by round-robin starting at the core after the last granted one (core 0 first after reset), latch dst_sel_o = grant and src_sel_o = (grant+1) mod NUM_CORES, and enter HALT next cycle.
REQ-009 HALT: halt_o SHALL be all ones; the block SHALL enter COPY the cycle after halted_i is all ones; a timeout counter SHALL increment each HALT cycle.
REQ-010 Timeout: when HALT_TIMEOUT cycles elapse without full acknowledge, the block SHALL enter FAIL, set fail_o, and hold halt_o all ones until reset.
REQ-011 COPY: rd_addr_o SHALL step 0..NUM_REG-1, one per cycle.
REQ-012 COPY: wr_en_o SHALL be high the cycle after each read, with wr_addr_o = previous rd_addr_o and wr_data_o = rd_data_i, giving exactly NUM_REG writes.
REQ-013 COPY occupies NUM_REG+1 cycles; after the last write the block SHALL enter RESUME.
REQ-014 RESUME lasts one cycle: resume_o = 1, halt_o = 0, the granted pending bit clears, and recovery_count_o increments, saturating at 255; the next state is IDLE.
REQ-015 busy_o SHALL be 1 in HALT, COPY, RESUME and FAIL, and 0 in IDLE.
REQ-016 Errors arriving during HALT or COPY: errors from non-granted cores SHALL stay pending and be serviced afterwards in round-robin order; errors from the granted core are absorbed.
REQ-017 An error from the granted core in the RESUME cycle SHALL re-set its pending bit.
REQ-018 Outside COPY, wr_en_o SHALL be 0.
REQ-019 Outside HALT, COPY and FAIL, halt_o SHALL be 0.
REQ-020 Minimum latency from error_i to resume_o, with immediate acknowledge: 1 (latch) + 1 (IDLE) + 1 (HALT) + NUM_REG+1 (COPY) = NUM_REG+4 cycles.

Reset
REQ-021 rst_i asserted at any time, including mid-COPY, SHALL immediately force:
- state IDLE
- halt_o, resume_o, wr_en_o, busy_o, fail_o = 0
- all pending bits, recovery_count_o, rd_addr_o, wr_addr_o, src_sel_o, dst_sel_o, timeout counter = 0
- round-robin pointer such that the next grant is core 0
REQ-022 A partial copy interrupted by reset SHALL NOT be resumed.

Verification
REQ-023 Single error: pulse error_i=4'b0100 with halted_i tied to halt_o -> dst_sel_o=2, src_sel_o=3, 32 writes with addresses 0..31 and data equal to the source, resume_o pulse at cycle 36, recovery_count_o=1.
REQ-024 Simultaneous errors: error_i=4'b1001 -> core 0 is serviced first, then core 3 (src_sel_o=0), two resume pulses, recovery_count_o=2.
REQ-025 Halt timeout: halted_i=4'b0111 held -> after 15 HALT cycles fail_o=1, busy_o=1, halt_o=4'b1111, no writes.
REQ-026 Reset mid-COPY at rd_addr_o=10 -> all outputs zero the same cycle, pending bits cleared, no resume_o.
REQ-027 Error during COPY: core 1 errors while core 2 is being repaired -> core 1 is serviced immediately after RESUME with no lost request.
REQ-028 Saturation: 260 sequential recoveries -> recovery_count_o stops at 255.
